// File: rtl/ram4k_responder.sv
// ram4k_responder: single-port word memory behind a valid/ready request port.
// Writes complete at the accept edge and produce no response. Reads pass
// through one capture stage (S1) into a small response FIFO. Request
// acceptance is throttled so that the capture stage always has a FIFO slot
// to drain into, so no response is ever dropped.
module ram4k_responder #(
    parameter int DEPTH_LOG2 = 12,
    parameter int WIDTH      = 16,
    parameter int RSP_DEPTH  = 2      // 2 or 4
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [DEPTH_LOG2-1:0] req_address,
    input  logic [WIDTH-1:0]      req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [DEPTH_LOG2-1:0] rsp_address,
    output logic [15:0]           wr_count
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;

    logic [WIDTH-1:0]      mem [2**DEPTH_LOG2];

    logic                  s1_valid;
    logic [WIDTH-1:0]      s1_data;
    logic [DEPTH_LOG2-1:0] s1_addr;

    logic [WIDTH-1:0]      fifo_data [RSP_DEPTH];
    logic [DEPTH_LOG2-1:0] fifo_addr [RSP_DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         fifo_count;

    logic [15:0]           wr_count_r;

    logic [OW-1:0]         occupancy;
    logic                  accept;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  push;
    logic                  pop;

    // Ready depends only on registered occupancy (plus reset), so a request
    // accepted into S1 is guaranteed a FIFO slot on the following edge.
    assign occupancy = OW'(fifo_count) + OW'(s1_valid);
    assign req_ready = !reset && (occupancy < OW'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;
    assign wr_accept = accept && req_write;
    assign rd_accept = accept && !req_write;

    assign rsp_valid   = (fifo_count != '0);
    assign rsp_data    = rsp_valid ? fifo_data[head] : '0;
    assign rsp_address = rsp_valid ? fifo_addr[head] : '0;
    assign wr_count    = wr_count_r;

    assign pop  = rsp_valid && rsp_ready;
    // S1 drains when there is room, including room freed by a same-edge pop.
    assign push = s1_valid && ((fifo_count < CW'(RSP_DEPTH)) || pop);

    // Storage write; memory contents are deliberately not reset.
    always_ff @(posedge CLK) begin
        if (wr_accept) begin
            mem[req_address] <= req_data;
        end
    end

    // Read capture stage: holds a read until it can move into the FIFO.
    always_ff @(posedge CLK) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_addr  <= '0;
        end else if (rd_accept) begin
            s1_valid <= 1'b1;
            s1_data  <= mem[req_address];
            s1_addr  <= req_address;
        end else if (push) begin
            s1_valid <= 1'b0;
        end
    end

    // Response FIFO storage and pointers; count tracks push minus pop.
    always_ff @(posedge CLK) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_data[tail] <= s1_data;
                fifo_addr[tail] <= s1_addr;
                tail            <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    // Accepted-write counter, saturating at all-ones.
    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_count_r <= '0;
        end else if (wr_accept && (wr_count_r != 16'hFFFF)) begin
            wr_count_r <= wr_count_r + 16'd1;
        end
    end

endmodule
